seg_scan_ctrl: RTL and testbench
================================

Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for a common-anode multi-digit 7-segment display.
- Takes a packed hex word, one nibble per digit.
- Steps through the digits one at a time and drives a single shared segment bus plus one active-low anode per digit.
- Applies a blanking guard between digits to suppress ghosting.
- Supports leading-zero suppression and per-digit enable masking.
- Sits between the datapath registers and the board display pins.

Parameters:
- NUM_DIGITS, 4: number of digits scanned; 1 to 8.
- REFRESH_DIV, 50000: clock cycles per digit slot; must be > BLANK_CYCLES.
- BLANK_CYCLES, 500: cycles at slot start with all anodes off; 0 disables blanking.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  scan enable.
- data  in  4*NUM_DIGITS  hex values; nibble i ([4i+3:4i]) is digit i; digit 0 is rightmost.
- dp_in  in  NUM_DIGITS  decimal point request per digit, active-high.
- digit_en  in  NUM_DIGITS  per-digit display mask; 0 blanks that digit.
- lz_suppress  in  1  blank leading zeros when high.
- an  out  NUM_DIGITS  anode selects, active-low.
- seg  out  7  segments {a,b,c,d,e,f,g}, active-low.
- dp  out  1  decimal point, active-low.
- frame_tick  out  1  one-cycle pulse at the end of each full scan frame.

Behaviour:
- Reset (rst sampled high): an all 1, seg 7'b1111111, dp 1, frame_tick 0; state IDLE, digit index 0, counters 0. Reset overrides en at any point mid-slot.
- States:
  - IDLE: outputs off.
  - BLANK: an all 1, seg 7'b1111111, dp 1.
  - SHOW: selected digit driven.
- IDLE -> BLANK (digit 0): on the edge where en is sampled high. If BLANK_CYCLES=0, go directly to SHOW.
- Slot timing:
  - Slot cycle counter runs 0..REFRESH_DIV-1.
  - Cycles 0..BLANK_CYCLES-1 are BLANK; remaining cycles are SHOW.
  - On the last cycle, the digit index increments, wrapping NUM_DIGITS-1 -> 0, and the next slot starts in BLANK.
- Outputs are registered and reflect the current state/counter in the same cycle; no extra pipeline latency.
- Snapshot: data, dp_in, digit_en and lz_suppress are latched into an internal frame register on the first cycle of digit 0's slot. The whole frame displays the snapshot, so input changes mid-frame never tear.
- SHOW, digit i:
  - an[i]=0, all other anodes 1.
  - seg comes from the internal 16-entry active-low decode: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
  - dp = ~dp_snap[i].
- Blanked digit (masked or suppressed): the slot is still consumed, keeping duty uniform. an stays all 1, seg 7'b1111111, dp 1.
  - Masked: digit_en_snap[i]=0.
  - Suppressed: lz_suppress set, all digits j>=i have nibble 0 and dp_snap 0, and i != 0. Digit 0 is never suppressed.
- frame_tick: high exactly on the last cycle of digit NUM_DIGITS-1's slot, otherwise 0. Only produced while scanning.
- en sampled low in any state: next cycle goes to IDLE with outputs off and counters/index cleared. Re-enable restarts at digit 0 BLANK with a fresh snapshot.
- No more than one an bit is ever low at any time.

Test Plan:
All tests use NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2, en raised at cycle 0, frame length 32.
- Basic scan: data=16'h12A0, digit_en=4'hF, lz off, dp_in=0.
  - Cycles 0-1: an=1111.
  - Cycles 2-7: an=1110, seg=0000001.
  - Cycles 10-15: an=1101, seg=0001000.
  - Cycles 18-23: an=1011, seg=0010010.
  - Cycles 26-31: an=0111, seg=1001111.
  - frame_tick=1 only at cycle 31, then repeats.
- Leading zeros: data=16'h0030, lz_suppress=1.
  - Digit 0 shows 0000001; digit 1 shows 0000110.
  - Digit 2 and digit 3 slots have an=1111.
  - With lz_suppress=0, digits 2 and 3 show 0000001.
- Snapshot: data changes 16'h1111 -> 16'h2222 at cycle 12. Cycles 12-31 still show 1001111; digit 0 at cycles 34-39 shows 0010010.
- Mask and dp: digit_en=4'b1010, dp_in=4'b0010. Slots 0 and 2 show an=1111. Slot 1 shows an=1101 with dp=0. Slot 3 shows dp=1.
- Enable drop: en low at cycle 20 gives an=1111, seg=1111111 from cycle 21. Re-enable at cycle 25 gives BLANK of digit 0 at cycles 26-27 and an=1110 at cycle 28.
- Reset mid-show: rst high at cycle 4 forces reset values at cycle 5. With en held high, releasing rst restarts at digit 0.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg_scan_ctrl
//
// Time-multiplexed scan controller for a common-anode multi-digit 7-segment
// display. Each digit receives one slot of REFRESH_DIV clock cycles. The first
// BLANK_CYCLES cycles of every slot drive all anodes off, which hides ghosting
// while the shared segment bus changes value. The rest of the slot shows the
// selected digit.
//
// The inputs are captured into a frame snapshot on the first cycle of digit
// 0's slot. A frame therefore never shows a mix of old and new values.
//
// Ports
//   clk          system clock
//   rst          synchronous, active-high reset
//   en           scan enable; when low the controller idles with outputs off
//   data         packed hex word; nibble i is digit i (digit 0 is rightmost)
//   dp_in        decimal point request per digit, active-high
//   digit_en     per-digit display mask; 0 blanks that digit
//   lz_suppress  blank leading zero digits (digit 0 is never suppressed)
//   an           anode selects, active-low; at most one bit is low
//   seg          segments {a,b,c,d,e,f,g}, active-low
//   dp           decimal point, active-low
//   frame_tick   one-cycle pulse on the last cycle of the final digit's slot
// ---------------------------------------------------------------------------
module seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [4*NUM_DIGITS-1:0] data,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    lz_suppress,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    frame_tick
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CW-1:0] LAST_CNT   = CW'(REFRESH_DIV - 1);
    localparam logic [DW-1:0] LAST_DIGIT = DW'(NUM_DIGITS - 1);
    localparam logic [CW-1:0] BLANK_END  = CW'(BLANK_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        SHOW
    } state_t;

    // State for the first cycle of a slot; skips blanking when it is disabled.
    localparam state_t SLOT_START = (BLANK_CYCLES > 0) ? BLANK : SHOW;

    state_t                  state_reg, state_next;
    logic [DW-1:0]           digit_reg, digit_next;
    logic [CW-1:0]           cnt_reg, cnt_next;
    logic [CW-1:0]           cnt_inc;
    logic                    load_snap;

    logic [4*NUM_DIGITS-1:0] data_snap_reg, data_snap_next;
    logic [NUM_DIGITS-1:0]   dp_snap_reg, dp_snap_next;
    logic [NUM_DIGITS-1:0]   den_snap_reg, den_snap_next;
    logic                    lz_snap_reg, lz_snap_next;

    logic [NUM_DIGITS-1:0]   an_reg, an_next;
    logic [6:0]              seg_reg, seg_next;
    logic                    dp_reg, dp_next;
    logic                    tick_reg, tick_next;

    // ------------------------------------------------------------------
    // Sequencing: slot counter, digit index and scan state
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        digit_next = digit_reg;
        cnt_next   = cnt_reg;
        load_snap  = 1'b0;
        cnt_inc    = cnt_reg + 1'b1;

        if (!en) begin
            state_next = IDLE;
            digit_next = '0;
            cnt_next   = '0;
        end else if (state_reg == IDLE) begin
            state_next = SLOT_START;
            digit_next = '0;
            cnt_next   = '0;
            load_snap  = 1'b1;
        end else if (cnt_reg == LAST_CNT) begin
            state_next = SLOT_START;
            cnt_next   = '0;
            if (digit_reg == LAST_DIGIT) begin
                digit_next = '0;
                load_snap  = 1'b1;
            end else begin
                digit_next = digit_reg + 1'b1;
            end
        end else begin
            cnt_next   = cnt_inc;
            state_next = (cnt_inc < BLANK_END) ? BLANK : SHOW;
        end
    end

    // Outputs are computed from the upcoming snapshot so that the first
    // slot of a frame already sees the freshly captured inputs.
    assign data_snap_next = load_snap ? data        : data_snap_reg;
    assign dp_snap_next   = load_snap ? dp_in       : dp_snap_reg;
    assign den_snap_next  = load_snap ? digit_en    : den_snap_reg;
    assign lz_snap_next   = load_snap ? lz_suppress : lz_snap_reg;

    // ------------------------------------------------------------------
    // Per-digit visibility
    // zero_from[i] is high when every digit at or above i is a zero nibble
    // with no decimal point, i.e. digit i is a leading zero.
    // ------------------------------------------------------------------
    logic [NUM_DIGITS:0]   zero_from;
    logic [NUM_DIGITS-1:0] digit_vis;
    logic [NUM_DIGITS-1:0] digit_sel;
    logic [NUM_DIGITS-1:0] show_vec;

    assign zero_from[NUM_DIGITS] = 1'b1;

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign zero_from[gi] = zero_from[gi+1]
                                 & (data_snap_next[4*gi +: 4] == 4'h0)
                                 & ~dp_snap_next[gi];
            if (gi == 0) begin : g_first
                assign digit_vis[gi] = den_snap_next[gi];
            end else begin : g_upper
                assign digit_vis[gi] = den_snap_next[gi]
                                     & ~(lz_snap_next & zero_from[gi]);
            end
            assign digit_sel[gi] = (digit_next == DW'(gi));
            assign show_vec[gi]  = digit_sel[gi] & digit_vis[gi]
                                 & (state_next == SHOW);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Segment decode, active-low {a,b,c,d,e,f,g}
    // ------------------------------------------------------------------
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0000100;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;
            4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    logic [3:0] nibble_cur;
    logic       dp_cur;
    logic       digit_on;

    always_comb begin
        nibble_cur = 4'h0;
        dp_cur     = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (digit_sel[i]) begin
                nibble_cur = data_snap_next[4*i +: 4];
                dp_cur     = dp_snap_next[i];
            end
        end
    end

    assign digit_on  = |show_vec;
    assign an_next   = ~show_vec;
    assign seg_next  = digit_on ? hex_to_seg(nibble_cur) : 7'b1111111;
    assign dp_next   = digit_on ? ~dp_cur : 1'b1;
    assign tick_next = (state_next != IDLE) && (digit_next == LAST_DIGIT)
                     && (cnt_next == LAST_CNT);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            digit_reg     <= '0;
            cnt_reg       <= '0;
            data_snap_reg <= '0;
            dp_snap_reg   <= '0;
            den_snap_reg  <= '0;
            lz_snap_reg   <= 1'b0;
            an_reg        <= '1;
            seg_reg       <= 7'b1111111;
            dp_reg        <= 1'b1;
            tick_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            digit_reg     <= digit_next;
            cnt_reg       <= cnt_next;
            data_snap_reg <= data_snap_next;
            dp_snap_reg   <= dp_snap_next;
            den_snap_reg  <= den_snap_next;
            lz_snap_reg   <= lz_snap_next;
            an_reg        <= an_next;
            seg_reg       <= seg_next;
            dp_reg        <= dp_next;
            tick_reg      <= tick_next;
        end
    end

    assign an         = an_reg;
    assign seg        = seg_reg;
    assign dp         = dp_reg;
    assign frame_tick = tick_reg;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seg_scan_ctrl
//
// Testbench for seg_scan_ctrl with NUM_DIGITS=4, REFRESH_DIV=8,
// BLANK_CYCLES=2 (frame length 32 cycles). A cycle-level reference model
// pushes the expected {an, seg, dp, frame_tick} into a scoreboard queue as each
// cycle's stimulus is applied. The entry is popped and compared once the DUT
// output for that cycle has settled.
// ---------------------------------------------------------------------------
module tb_seg_scan_ctrl;

    localparam int ND    = 4;
    localparam int RDIV  = 8;
    localparam int BLNK  = 2;
    localparam int FRAME = ND * RDIV;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [15:0]   data;
    logic [3:0]    dp_in;
    logic [3:0]    digit_en;
    logic          lz_suppress;
    logic [3:0]    an;
    logic [6:0]    seg;
    logic          dp;
    logic          frame_tick;

    seg_scan_ctrl #(
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (RDIV),
        .BLANK_CYCLES(BLNK)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .data       (data),
        .dp_in      (dp_in),
        .digit_en   (digit_en),
        .lz_suppress(lz_suppress),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Scoreboard entry: {an[3:0], seg[6:0], dp, frame_tick}
    logic [12:0] sb[$];

    logic [6:0] dec_tab [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    // Reference model state
    bit          m_active = 1'b0;
    int          m_k      = 0;
    logic [15:0] s_data   = '0;
    logic [3:0]  s_dp     = '0;
    logic [3:0]  s_den    = '0;
    bit          s_lz     = 1'b0;

    function automatic logic [12:0] model_out(bit act, int kk);
        int         slot;
        int         c;
        bit         tick;
        bit         blank;
        bit         allz;
        logic [3:0] nib;
        logic [3:0] an_e;
        if (!act) return {4'hF, 7'b1111111, 1'b1, 1'b0};
        slot = kk / RDIV;
        c    = kk % RDIV;
        tick = (kk == FRAME - 1);
        if (c < BLNK) return {4'hF, 7'b1111111, 1'b1, tick};
        blank = !s_den[slot];
        if (s_lz && slot != 0) begin
            allz = 1'b1;
            for (int j = slot; j < ND; j++) begin
                nib = s_data[4*j +: 4];
                if (nib != 4'h0 || s_dp[j]) allz = 1'b0;
            end
            if (allz) blank = 1'b1;
        end
        if (blank) return {4'hF, 7'b1111111, 1'b1, tick};
        an_e       = 4'hF;
        an_e[slot] = 1'b0;
        nib        = s_data[4*slot +: 4];
        return {an_e, dec_tab[nib], ~s_dp[slot], tick};
    endfunction

    // Advances the model by one clock edge using the inputs that the edge
    // samples, queues the expectation, and then steps the DUT past that edge.
    task automatic drive_cycle();
        if (rst) begin
            m_active = 1'b0;
        end else if (en) begin
            if (!m_active) begin
                m_active = 1'b1;
                m_k      = 0;
            end else begin
                m_k = (m_k + 1) % FRAME;
            end
            if (m_k == 0) begin
                s_data = data;
                s_dp   = dp_in;
                s_den  = digit_en;
                s_lz   = lz_suppress;
            end
        end else begin
            m_active = 1'b0;
        end
        sb.push_back(model_out(m_active, m_k));
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        logic [12:0] exp_v;
        logic [12:0] got;
        rst = 1'b1; en = 1'b1; data = 16'h8888; dp_in = 4'hF;
        digit_en = 4'hF; lz_suppress = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (c == 3) begin rst = 1'b0; en = 1'b0; end
            drive_cycle();
            exp_v = sb.pop_front();
            got   = {an, seg, dp, frame_tick};
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL reset c=%0d got an=%b seg=%b dp=%b tick=%b, expected an=%b seg=%b dp=%b tick=%b",
                         c, got[12:9], got[8:2], got[1], got[0],
                         exp_v[12:9], exp_v[8:2], exp_v[1], exp_v[0]);
            end
            $display("reset      c=%0d an=%b seg=%b dp=%b tick=%b", c, an, seg, dp, frame_tick);
        end
    endtask

    // Basic scan over more than one frame so frame_tick repetition is covered.
    task automatic test_basic_scan();
        logic [12:0] exp_v;
        logic [12:0] got;
        int          t;
        int          ticks;
        ticks = 0;
        rst = 1'b1; en = 1'b0; data = 16'h12A0; dp_in = 4'h0;
        digit_en = 4'hF; lz_suppress = 1'b0;
        for (int c = 0; c < 3 + 2*FRAME + 4; c++) begin
            t = c - 3;
            if (t == -1) begin rst = 1'b0; en = 1'b1; end
            drive_cycle();
            exp_v = sb.pop_front();
            got   = {an, seg, dp, frame_tick};
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL basic_scan cycle=%0d got an=%b seg=%b dp=%b tick=%b, expected an=%b seg=%b dp=%b tick=%b",
                         t + 1, got[12:9], got[8:2], got[1], got[0],
                         exp_v[12:9], exp_v[8:2], exp_v[1], exp_v[0]);
            end
            checks++;
            if ($countones(~an) > 1) begin
                errors++;
                $display("FAIL basic_onehot cycle=%0d got an=%b, expected at most one low bit", t + 1, an);
            end
            if (frame_tick) ticks++;
            $display("basic_scan cycle=%0d an=%b seg=%b dp=%b tick=%b", t + 1, an, seg, dp, frame_tick);
        end
        checks++;
        if (ticks !== 2) begin
            errors++;
            $display("FAIL basic_tick_count got %0d, expected 2", ticks);
        end
    endtask

    // Leading-zero suppression on, then off, then an all-zero word.
    task automatic test_lz();
        logic [12:0] exp_v;
        logic [12:0] got;
        logic [15:0] words [3] = '{16'h0030, 16'h0030, 16'h0000};
        bit          lzs   [3] = '{1'b1, 1'b0, 1'b1};
        for (int r = 0; r < 3; r++) begin
            rst = 1'b1; en = 1'b0; data = words[r]; dp_in = 4'h0;
            digit_en = 4'hF; lz_suppress = lzs[r];
            for (int c = 0; c < 3 + FRAME; c++) begin
                if (c == 2) begin rst = 1'b0; en = 1'b1; end
                drive_cycle();
                exp_v = sb.pop_front();
                got   = {an, seg, dp, frame_tick};
                checks++;
                if (got !== exp_v) begin
                    errors++;
                    $display("FAIL lz run=%0d cycle=%0d got an=%b seg=%b dp=%b tick=%b, expected an=%b seg=%b dp=%b tick=%b",
                             r, c - 2, got[12:9], got[8:2], got[1], got[0],
                             exp_v[12:9], exp_v[8:2], exp_v[1], exp_v[0]);
                end
                $display("lz         run=%0d cycle=%0d an=%b seg=%b", r, c - 2, an, seg);
            end
        end
    endtask

    // Input change mid-frame must not appear until the next frame.
    task automatic test_snapshot();
        logic [12:0] exp_v;
        logic [12:0] got;
        int          t;
        rst = 1'b1; en = 1'b0; data = 16'h1111; dp_in = 4'h0;
        digit_en = 4'hF; lz_suppress = 1'b0;
        for (int c = 0; c < 3 + 45; c++) begin
            t = c - 3;
            if (t == -1) begin rst = 1'b0; en = 1'b1; end
            if (t == 12) data = 16'h2222;
            drive_cycle();
            exp_v = sb.pop_front();
            got   = {an, seg, dp, frame_tick};
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL snapshot cycle=%0d got an=%b seg=%b dp=%b tick=%b, expected an=%b seg=%b dp=%b tick=%b",
                         t + 1, got[12:9], got[8:2], got[1], got[0],
                         exp_v[12:9], exp_v[8:2], exp_v[1], exp_v[0]);
            end
            $display("snapshot   cycle=%0d an=%b seg=%b", t + 1, an, seg);
        end
    endtask

    // Digit mask and decimal point handling.
    task automatic test_mask_dp();
        logic [12:0] exp_v;
        logic [12:0] got;
        rst = 1'b1; en = 1'b0; data = 16'h4321; dp_in = 4'b0010;
        digit_en = 4'b1010; lz_suppress = 1'b0;
        for (int c = 0; c < 3 + FRAME; c++) begin
            if (c == 2) begin rst = 1'b0; en = 1'b1; end
            drive_cycle();
            exp_v = sb.pop_front();
            got   = {an, seg, dp, frame_tick};
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL mask_dp cycle=%0d got an=%b seg=%b dp=%b tick=%b, expected an=%b seg=%b dp=%b tick=%b",
                         c - 2, got[12:9], got[8:2], got[1], got[0],
                         exp_v[12:9], exp_v[8:2], exp_v[1], exp_v[0]);
            end
            $display("mask_dp    cycle=%0d an=%b seg=%b dp=%b", c - 2, an, seg, dp);
        end
    endtask

    // Enable dropped mid-frame, then restored with new data.
    task automatic test_enable_drop();
        logic [12:0] exp_v;
        logic [12:0] got;
        int          t;
        rst = 1'b1; en = 1'b0; data = 16'h5678; dp_in = 4'h0;
        digit_en = 4'hF; lz_suppress = 1'b0;
        for (int c = 0; c < 3 + 40; c++) begin
            t = c - 3;
            if (t == -1) begin rst = 1'b0; en = 1'b1; end
            if (t == 20) en = 1'b0;
            if (t == 22) data = 16'h9ABC;
            if (t == 25) en = 1'b1;
            drive_cycle();
            exp_v = sb.pop_front();
            got   = {an, seg, dp, frame_tick};
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL enable_drop cycle=%0d got an=%b seg=%b dp=%b tick=%b, expected an=%b seg=%b dp=%b tick=%b",
                         t + 1, got[12:9], got[8:2], got[1], got[0],
                         exp_v[12:9], exp_v[8:2], exp_v[1], exp_v[0]);
            end
            $display("en_drop    cycle=%0d en=%b an=%b seg=%b", t + 1, en, an, seg);
        end
    endtask

    // Reset asserted during a SHOW cycle while en stays high.
    task automatic test_reset_mid_show();
        logic [12:0] exp_v;
        logic [12:0] got;
        int          t;
        rst = 1'b1; en = 1'b0; data = 16'hDEF0; dp_in = 4'b0001;
        digit_en = 4'hF; lz_suppress = 1'b0;
        for (int c = 0; c < 3 + 20; c++) begin
            t = c - 3;
            if (t == -1) begin rst = 1'b0; en = 1'b1; end
            if (t == 4) rst = 1'b1;
            if (t == 5) rst = 1'b0;
            drive_cycle();
            exp_v = sb.pop_front();
            got   = {an, seg, dp, frame_tick};
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL reset_mid cycle=%0d got an=%b seg=%b dp=%b tick=%b, expected an=%b seg=%b dp=%b tick=%b",
                         t + 1, got[12:9], got[8:2], got[1], got[0],
                         exp_v[12:9], exp_v[8:2], exp_v[1], exp_v[0]);
            end
            $display("reset_mid  cycle=%0d rst=%b an=%b seg=%b dp=%b", t + 1, rst, an, seg, dp);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; data = '0; dp_in = '0;
        digit_en = '0; lz_suppress = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_basic_scan();
        test_lz();
        test_snapshot();
        test_mask_dp();
        test_enable_drop();
        test_reset_mid_show();
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d entries left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
